// File: rtl/aes_host_driver.sv
// Host-side master for the AES-128 core dword port: load key/plaintext, wait for done, read ciphertext.
// Latency 13 + done wait + READ_LATENCY cycles from accept; one request in flight, result held until out_ready.
module aes_host_driver #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int READ_LATENCY   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         out_error,
  output logic         busy,
  output logic         core_start_n,
  output logic         core_start_read_n,
  output logic [31:0]  core_dword_in,
  input  logic [31:0]  core_dword_out,
  input  logic         core_done
);

  localparam int         CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] SKIP  = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_DONE,
    S_READ_REQ,
    S_READ,
    S_RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       skip_q, skip_d;
  logic [1:0]       w_q, w_d;
  logic [255:0]     data_q, data_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_error_q, out_error_d;
  logic [127:0]     out_block_q, out_block_d;
  logic             busy_q, busy_d;
  logic             start_n_q, start_n_d;
  logic             start_read_n_q, start_read_n_d;
  logic [31:0]      dword_in_q, dword_in_d;

  // Latched {key, plaintext} as eight dwords, word 0 in the top bits.
  function automatic logic [31:0] load_word(input logic [255:0] d, input logic [2:0] k);
    logic [255:0] s;
    s = d << (32 * k);
    return s[255:224];
  endfunction

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    cnt_d          = cnt_q;
    skip_d         = skip_q;
    w_d            = w_q;
    data_d         = data_q;
    in_ready_d     = 1'b0;
    out_valid_d    = out_valid_q;
    out_error_d    = out_error_q;
    out_block_d    = out_block_q;
    start_n_d      = 1'b1;
    start_read_n_d = 1'b1;
    dword_in_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d     = {in_key, in_block};
          state_d    = S_LOAD;
          k_d        = 3'd0;
          dword_in_d = in_key[127:96];
          start_n_d  = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (k_q == 3'd7) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else begin
          k_d        = k_q + 3'd1;
          dword_in_d = load_word(data_q, k_q + 3'd1);
        end
      end
      S_WAIT_DONE: begin
        if (core_done) begin
          state_d        = S_READ_REQ;
          start_read_n_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Timeout result: error flag with a zeroed block, never partial data.
          state_d     = S_RESULT;
          out_valid_d = 1'b1;
          out_error_d = 1'b1;
          out_block_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ_REQ: begin
        state_d = S_READ;
        skip_d  = SKIP;
        w_d     = 2'd0;
      end
      S_READ: begin
        if (skip_q != 2'd0) begin
          skip_d = skip_q - 2'd1;
        end else begin
          case (w_q)
            2'd0:    out_block_d[127:96] = core_dword_out;
            2'd1:    out_block_d[95:64]  = core_dword_out;
            2'd2:    out_block_d[63:32]  = core_dword_out;
            default: out_block_d[31:0]   = core_dword_out;
          endcase
          w_d = w_q + 2'd1;
          if (w_q == 2'd3) begin
            state_d     = S_RESULT;
            out_valid_d = 1'b1;
            out_error_d = 1'b0;
          end
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      cnt_q          <= '0;
      skip_q         <= '0;
      w_q            <= '0;
      data_q         <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_error_q    <= 1'b0;
      out_block_q    <= '0;
      busy_q         <= 1'b0;
      start_n_q      <= 1'b1;
      start_read_n_q <= 1'b1;
      dword_in_q     <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      cnt_q          <= cnt_d;
      skip_q         <= skip_d;
      w_q            <= w_d;
      data_q         <= data_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_error_q    <= out_error_d;
      out_block_q    <= out_block_d;
      busy_q         <= busy_d;
      start_n_q      <= start_n_d;
      start_read_n_q <= start_read_n_d;
      dword_in_q     <= dword_in_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_error         = out_error_q;
  assign out_block         = out_block_q;
  assign busy              = busy_q;
  assign core_start_n      = start_n_q;
  assign core_start_read_n = start_read_n_q;
  assign core_dword_in     = dword_in_q;

endmodule
